// File: rtl/morse_element_decoder.sv
// Morse receive stage: times marks/spaces of the keyed level in units, builds
// dot/dash patterns into characters and hands characters/word tokens out over valid/ready.
module morse_element_decoder #(
    parameter int CLK_SPEED  = 16_000_000,
    parameter int MAX_ELEMS  = 6,
    parameter int DASH_UNITS = 3,
    parameter int LETTER_GAP = 3,
    parameter int WORD_GAP   = 7,
    parameter int MAX_MARK   = 7
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 UNIT_TICK,
    input  logic                 ONOFF,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [MAX_ELEMS-1:0] OUT_BITS,
    output logic [2:0]           OUT_LEN,
    output logic                 OUT_WORD,
    output logic                 OUT_ERR,
    output logic                 OVERFLOW
);

    if (CLK_SPEED <= 0 || MAX_ELEMS < 1 || MAX_ELEMS > 7) begin : g_bad_params
        $error("morse_element_decoder: illegal parameter set");
    end

    localparam logic [3:0] DASH4 = 4'(DASH_UNITS);
    localparam logic [3:0] LGAP4 = 4'(LETTER_GAP);
    localparam logic [3:0] WGAP4 = 4'(WORD_GAP);
    localparam logic [3:0] MMRK4 = 4'(MAX_MARK);
    localparam logic [2:0] MAXE3 = 3'(MAX_ELEMS);

    typedef enum logic [1:0] {IDLE, MARK, SPACE, WORDWAIT} state_t;

    state_t               state_q, state_d;
    logic                 s_meta_q, s_q, s_prev_q;
    logic [3:0]           cnt_q, cnt_d, cnt_inc;
    logic [MAX_ELEMS-1:0] elems_q, elems_d;
    logic [2:0]           nelem_q, nelem_d;
    logic                 err_q, err_d;
    logic                 rise, fall, at_letter, at_word;
    logic                 emit_char, emit_word;

    logic                 out_valid_q, out_valid_d;
    logic [MAX_ELEMS-1:0] out_bits_q, out_bits_d;
    logic [2:0]           out_len_q, out_len_d;
    logic                 out_word_q, out_word_d;
    logic                 out_err_q, out_err_d;
    logic                 ovf_q, ovf_d;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            s_meta_q    <= 1'b0;
            s_q         <= 1'b0;
            s_prev_q    <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            elems_q     <= '0;
            nelem_q     <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_bits_q  <= '0;
            out_len_q   <= '0;
            out_word_q  <= 1'b0;
            out_err_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            s_meta_q    <= ONOFF;
            s_q         <= s_meta_q;
            s_prev_q    <= s_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            elems_q     <= elems_d;
            nelem_q     <= nelem_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_bits_q  <= out_bits_d;
            out_len_q   <= out_len_d;
            out_word_q  <= out_word_d;
            out_err_q   <= out_err_d;
            ovf_q       <= ovf_d;
        end
    end

    // Edges win over a coincident tick: classification sees the pre-increment count.
    always_comb begin
        rise      = s_q & ~s_prev_q;
        fall      = ~s_q & s_prev_q;
        cnt_inc   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        cnt_d     = (rise | fall) ? 4'd0 : (UNIT_TICK ? cnt_inc : cnt_q);
        at_letter = UNIT_TICK && (cnt_q + 4'd1 == LGAP4);
        at_word   = UNIT_TICK && (cnt_q + 4'd1 == WGAP4);
    end

    always_comb begin
        state_d   = state_q;
        elems_d   = elems_q;
        nelem_d   = nelem_q;
        err_d     = err_q;
        emit_char = 1'b0;
        emit_word = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) state_d = MARK;
            end
            MARK: begin
                if (fall) begin
                    if (cnt_q == 4'd0) begin
                        state_d = (nelem_q == 3'd0) ? WORDWAIT : SPACE;
                    end else begin
                        if (nelem_q == MAXE3) begin
                            err_d = 1'b1;
                        end else begin
                            elems_d[nelem_q] = (cnt_q >= DASH4);
                            nelem_d          = nelem_q + 3'd1;
                        end
                        if (cnt_q > MMRK4) err_d = 1'b1;
                        state_d = SPACE;
                    end
                end
            end
            SPACE: begin
                if (rise) begin
                    state_d = MARK;
                end else if (at_letter) begin
                    emit_char = 1'b1;
                    elems_d   = '0;
                    nelem_d   = '0;
                    err_d     = 1'b0;
                    state_d   = WORDWAIT;
                end
            end
            WORDWAIT: begin
                if (rise) begin
                    state_d = MARK;
                end else if (at_word) begin
                    emit_word = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Single output slot: a result arriving while the slot is stalled is dropped.
    always_comb begin
        out_valid_d = out_valid_q;
        out_bits_d  = out_bits_q;
        out_len_d   = out_len_q;
        out_word_d  = out_word_q;
        out_err_d   = out_err_q;
        ovf_d       = ovf_q;
        if (emit_char || emit_word) begin
            if (!out_valid_q || OUT_READY) begin
                out_valid_d = 1'b1;
                out_bits_d  = emit_word ? '0 : elems_q;
                out_len_d   = emit_word ? 3'd0 : nelem_q;
                out_word_d  = emit_word;
                out_err_d   = emit_word ? 1'b0 : err_q;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (out_valid_q && OUT_READY) begin
            out_valid_d = 1'b0;
        end
    end

    assign OUT_VALID = out_valid_q;
    assign OUT_BITS  = out_bits_q;
    assign OUT_LEN   = out_len_q;
    assign OUT_WORD  = out_word_q;
    assign OUT_ERR   = out_err_q;
    assign OVERFLOW  = ovf_q;

endmodule

// File: doc/morse_element_decoder.md
Name: morse_element_decoder

Overview:
- Downstream receive stage for the Morse transmit path.
- Samples the keyed on/off level (the same signal that drives PIN_13/LED) against the per-unit strobe derived from the unit generator.
- Measures mark and space durations in units, classifies each mark as dot or dash, and assembles elements into characters.
- Hands completed characters and word-gap tokens to a consumer over a valid/ready interface; used for loopback self-check and optical receive.

Parameters:
- CLK_SPEED, 16_000_000, system clock in Hz (documentation only; no timing derived from it).
- MAX_ELEMS, 6, maximum elements per character (width of OUT_BITS).
- DASH_UNITS, 3, minimum mark length in units classified as dash.
- LETTER_GAP, 3, space length in units that closes a character.
- WORD_GAP, 7, space length in units that emits a word-gap token.
- MAX_MARK, 7, longest legal mark in units; longer marks set the error flag.

Ports:
- CLK, input, 1: system clock, 16 MHz.
- RST_N, input, 1: synchronous, active-low reset.
- UNIT_TICK, input, 1: single-CLK pulse, once per Morse unit.
- ONOFF, input, 1: keyed level, 1 = mark; asynchronous to CLK.
- OUT_VALID, output, 1: character/token available.
- OUT_READY, input, 1: consumer accepts when high with OUT_VALID.
- OUT_BITS, output, MAX_ELEMS: element pattern; bit0 = first element; 1 = dash, 0 = dot; unused bits 0.
- OUT_LEN, output, 3: element count 0..MAX_ELEMS; 0 marks a word-gap token.
- OUT_WORD, output, 1: 1 = word-gap token.
- OUT_ERR, output, 1: character contained an over-long mark or too many elements.
- OVERFLOW, output, 1: sticky; a result was dropped under backpressure.

Behaviour:
- Reset: one clock, synchronous, active-low. RST_N low at a CLK edge clears all state. Outputs after reset: OUT_VALID=0, OUT_BITS=0, OUT_LEN=0, OUT_WORD=0, OUT_ERR=0, OVERFLOW=0. FSM returns to IDLE. A reset mid-mark or mid-space discards the partial character.
- Input sync: ONOFF passes through a 2-FF synchronizer. All classification uses the synchronized level S. An edge on S is detected the cycle after S changes.
- Counter: 4-bit unit counter, incremented on UNIT_TICK, saturating at 15, cleared on every S edge.
- FSM states: IDLE, MARK, SPACE, WORDWAIT.
- IDLE: wait for a rising S edge → MARK. No output is produced in IDLE.
- MARK, on a falling S edge, classify the mark by its unit count:
  - count 0: glitch; discard with no element added → SPACE (or WORDWAIT if no elements are held).
  - 1..DASH_UNITS-1: append dot.
  - DASH_UNITS..MAX_MARK: append dash.
  - greater than MAX_MARK: append dash and set char_err.
  - Appending when MAX_ELEMS elements are already held: no append; set char_err. The count stays at MAX_ELEMS.
  - After classification → SPACE.
- SPACE:
  - Rising S edge before the count reaches LETTER_GAP: intra-character gap → MARK.
  - On the UNIT_TICK at which the count reaches LETTER_GAP: emit the character (LEN = elements held, BITS, ERR = char_err, WORD = 0). Clear the element buffer and char_err → WORDWAIT.
- WORDWAIT:
  - On the UNIT_TICK at which the space count reaches WORD_GAP: emit a token (LEN=0, BITS=0, WORD=1, ERR=0) → IDLE.
  - Rising S edge earlier: → MARK with no token emitted.
  - A reset-initiated IDLE never emits a word token.
- Emission latency: OUT_* registered; OUT_VALID rises the cycle after the triggering UNIT_TICK.
- Handshake:
  - OUT_* hold stable while OUT_VALID=1 and OUT_READY=0.
  - Transfer occurs on a cycle where OUT_VALID and OUT_READY are both high; OUT_VALID drops the next cycle unless a new result loads.
  - New result while the slot is full and OUT_READY=0: drop the new result, keep the old one, set OVERFLOW.
  - New result in the same cycle as a transfer: load the new result; OUT_VALID stays 1; no overflow.
- OVERFLOW clears only on reset.
- Simultaneous UNIT_TICK and S edge: the edge takes priority. Classify on the pre-increment count, then clear the counter.

Test Plan:
- "A": mark 1u, space 1u, mark 3u, space 3u, OUT_READY=1 → one transfer with LEN=2, BITS=6'b000010, ERR=0, WORD=0. OUT_VALID rises 1 cycle after the 3rd space tick.
- Continue the "A" space to 7u → second transfer with LEN=0, WORD=1, BITS=0. Hold ONOFF low for 20 more units → no further output.
- Seven 1u dots separated by 1u spaces, then space 3u → LEN=6, BITS=0, ERR=1.
- OUT_READY=0; send "E" (1u mark) and let the space reach 7u → "E" held on outputs, word token dropped, OVERFLOW=1. Raise OUT_READY → "E" transfers, OUT_VALID→0.
- ONOFF high for 2 CLK with no UNIT_TICK, then 5u of space → no element recorded, no OUT_VALID.
- RST_N low for 1 cycle during a 2u mark, then a 1u mark and 3u space → LEN=1, BITS=0; all outputs 0 in the cycle after reset.
